board_io_conditioner: RTL and testbench

- Parametrised board-input front end for FPGA top levels. It generalises the hard-coded power-on reset counter and switch inversion into a single block.
- Each of NumInputs asynchronous pins is synchronised, polarity-normalised through a per-bit active-low mask, and debounced. Rise and fall event pulses and a sticky change interrupt are generated from the debounced values.
- A power-on reset sequencer holds the system reset for a programmable time, then releases it under control of a debounced reset-button channel.
- Sits between the board pins and the demo-system GPIO/reset inputs.

---
 rtl/board_io_conditioner_if.sv | 22 ++
 rtl/board_io_conditioner.sv | 66 ++++++
 tb/tb_board_io_conditioner.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/board_io_conditioner_if.sv
// board_io_conditioner_if: pin inputs, IRQ control and conditioned outputs for board_io_conditioner
interface board_io_conditioner_if #(
  parameter int NumInputs = 13
);
  logic [NumInputs-1:0] pins_i;
  logic [NumInputs-1:0] irq_en_i;
  logic                 irq_clr_i;
  logic [NumInputs-1:0] level_o;
  logic [NumInputs-1:0] rise_o;
  logic [NumInputs-1:0] fall_o;
  logic                 irq_o;
  logic                 rst_out_no;
  logic                 por_done_o;
  modport master (
    output pins_i, irq_en_i, irq_clr_i,
    input  level_o, rise_o, fall_o, irq_o, rst_out_no, por_done_o
  );
  modport slave (
    input  pins_i, irq_en_i, irq_clr_i,
    output level_o, rise_o, fall_o, irq_o, rst_out_no, por_done_o
  );
endinterface

// File: rtl/board_io_conditioner.sv
// board_io_conditioner: synchronise, normalise and debounce board pins; events, sticky irq, por sequencer
module board_io_conditioner #(
  parameter int                   NumInputs      = 13,
  parameter logic [NumInputs-1:0] ActiveLowMask  = {NumInputs{1'b1}},
  parameter int                   SyncStages     = 2,
  parameter int                   DebounceCycles = 50000,
  parameter int                   RstHoldCycles  = 200,
  parameter int                   RstBtnIdx      = 0
) (
  input logic                    clk_sys_i,
  input logic                    rst_sys_i,
  board_io_conditioner_if.slave  io
);
  localparam int CW = $clog2(DebounceCycles + 1);
  localparam int HW = $clog2(RstHoldCycles + 1);
  localparam logic [CW-1:0] CntMax  = CW'(DebounceCycles - 1);
  localparam logic [HW-1:0] HoldMax = HW'(RstHoldCycles);
  logic [NumInputs-1:0] sync_q [SyncStages];
  logic [NumInputs-1:0] s, upd, level_q, level_d, rise_q, fall_q;
  logic [CW-1:0]        cnt_q [NumInputs];
  logic [CW-1:0]        cnt_d [NumInputs];
  logic [HW-1:0]        hold_q, hold_d;
  logic                 irq_q, por_done_q, rst_out_q;
  // Debounce: a channel flips only after DebounceCycles consecutive disagreeing cycles
  always_comb begin
    s = sync_q[SyncStages-1] ^ ActiveLowMask;
    upd = '0;
    for (int i = 0; i < NumInputs; i++) begin
      upd[i] = (s[i] != level_q[i]) && (cnt_q[i] == CntMax);
      cnt_d[i] = (s[i] == level_q[i] || upd[i]) ? '0 : cnt_q[i] + 1'b1;
    end
    level_d = level_q ^ upd;
    hold_d = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;
  end
  // All state: sync chain, debounced levels, events, sticky irq and the reset sequencer
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      for (int k = 0; k < SyncStages; k++) sync_q[k] <= ActiveLowMask;
      for (int i = 0; i < NumInputs; i++) cnt_q[i] <= '0;
      level_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      irq_q      <= 1'b0;
      hold_q     <= '0;
      por_done_q <= 1'b0;
      rst_out_q  <= 1'b0;
    end else begin
      sync_q[0] <= io.pins_i;
      for (int k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < NumInputs; i++) cnt_q[i] <= cnt_d[i];
      level_q    <= level_d;
      rise_q     <= upd & s;
      fall_q     <= upd & ~s;
      irq_q      <= (|((rise_q | fall_q) & io.irq_en_i)) | (irq_q & ~io.irq_clr_i);
      hold_q     <= hold_d;
      por_done_q <= (hold_d == HoldMax);
      rst_out_q  <= por_done_q & ~level_q[RstBtnIdx];
    end
  end
  assign io.level_o    = level_q;
  assign io.rise_o     = rise_q;
  assign io.fall_o     = fall_q;
  assign io.irq_o      = irq_q;
  assign io.rst_out_no = rst_out_q;
  assign io.por_done_o = por_done_q;
endmodule

// File: tb/tb_board_io_conditioner.sv
// tb_board_io_conditioner: directed checks of sync/debounce, events, irq and reset sequencing
module tb_board_io_conditioner;
  logic clk, rst;
  int tests = 0;
  int fails = 0;
  board_io_conditioner_if #(.NumInputs(4)) bus ();
  board_io_conditioner #(
    .NumInputs(4), .ActiveLowMask(4'b0011), .SyncStages(2),
    .DebounceCycles(4), .RstHoldCycles(10), .RstBtnIdx(0)
  ) dut (
    .clk_sys_i(clk),
    .rst_sys_i(rst),
    .io(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_level"}, bus.level_o, 0);
    chk({tag, "_rise"}, bus.rise_o, 0);
    chk({tag, "_fall"}, bus.fall_o, 0);
    chk({tag, "_irq"}, bus.irq_o, 0);
    chk({tag, "_rstn"}, bus.rst_out_no, 0);
    chk({tag, "_por"}, bus.por_done_o, 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.pins_i = 4'b0011;
    bus.irq_en_i = 4'b0100;
    bus.irq_clr_i = 1'b0;
    step(3);
    chk_reset("rst0");
    rst = 1'b0;
    chk("c0_rstn", bus.rst_out_no, 0);
    chk("c0_por", bus.por_done_o, 0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("t1_rstn", bus.rst_out_no, k >= 11);
      chk("t1_por", bus.por_done_o, k >= 10);
      chk("t1_level", bus.level_o, 0);
    end
    bus.pins_i = 4'b0111;
    step(5);
    chk("t2_level_early", bus.level_o, 4'b0000);
    step(1);
    chk("t2_level", bus.level_o, 4'b0100);
    chk("t2_rise", bus.rise_o, 4'b0100);
    chk("t2_irq_pre", bus.irq_o, 0);
    step(1);
    chk("t2_rise_end", bus.rise_o, 4'b0000);
    chk("t2_irq", bus.irq_o, 1);
    bus.irq_clr_i = 1'b1;
    step(1);
    bus.irq_clr_i = 1'b0;
    chk("t3_irq_clr", bus.irq_o, 0);
    bus.pins_i = 4'b0101;
    step(3);
    bus.pins_i = 4'b0111;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("t3_evt", bus.rise_o | bus.fall_o, 0);
      chk("t3_level", bus.level_o, 4'b0100);
    end
    chk("t3_irq", bus.irq_o, 0);
    bus.pins_i = 4'b0110;
    step(5);
    chk("t4_level_early", bus.level_o, 4'b0100);
    step(1);
    chk("t4_level", bus.level_o, 4'b0101);
    chk("t4_rise", bus.rise_o, 4'b0001);
    chk("t4_rstn_hold", bus.rst_out_no, 1);
    step(1);
    chk("t4_rstn_low", bus.rst_out_no, 0);
    step(1);
    bus.pins_i = 4'b0111;
    step(5);
    chk("t4_rel_level_early", bus.level_o, 4'b0101);
    step(1);
    chk("t4_rel_level", bus.level_o, 4'b0100);
    chk("t4_fall", bus.fall_o, 4'b0001);
    chk("t4_rstn_still_low", bus.rst_out_no, 0);
    step(1);
    chk("t4_rstn_high", bus.rst_out_no, 1);
    chk("t4_irq", bus.irq_o, 0);
    bus.irq_en_i = 4'b1100;
    bus.pins_i = 4'b1111;
    step(6);
    chk("t5_rise", bus.rise_o, 4'b1000);
    chk("t5_irq_pre", bus.irq_o, 0);
    step(1);
    chk("t5_irq", bus.irq_o, 1);
    chk("t5_level", bus.level_o, 4'b1100);
    bus.pins_i = 4'b0111;
    step(5);
    chk("t5_fall_early", bus.fall_o, 4'b0000);
    step(1);
    chk("t5_fall", bus.fall_o, 4'b1000);
    bus.irq_clr_i = 1'b1;
    step(1);
    bus.irq_clr_i = 1'b0;
    chk("t5_set_wins", bus.irq_o, 1);
    chk("t5_fall_end", bus.fall_o, 4'b0000);
    bus.irq_clr_i = 1'b1;
    step(1);
    bus.irq_clr_i = 1'b0;
    chk("t5_cleared", bus.irq_o, 0);
    chk("t6_pre_rstn", bus.rst_out_no, 1);
    rst = 1'b1;
    #2;
    chk_reset("t6_async");
    step(1);
    bus.pins_i = 4'b0011;
    rst = 1'b0;
    step(3);
    bus.pins_i = 4'b0111;
    step(4);
    chk("t6_mid_level", bus.level_o, 0);
    chk("t6_mid_por", bus.por_done_o, 0);
    rst = 1'b1;
    #2;
    chk_reset("t6_mid");
    step(1);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("t6_rstn", bus.rst_out_no, k >= 11);
      chk("t6_por", bus.por_done_o, k >= 10);
      if (k == 5) chk("t6_level_early", bus.level_o, 4'b0000);
      if (k == 6) begin
        chk("t6_level", bus.level_o, 4'b0100);
        chk("t6_rise", bus.rise_o, 4'b0100);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
